cache_axi_rd_arbiter: RTL
=========================

CACHE_AXI_RD_ARBITER -- requirements
Module: cache_axi_rd_arbiter

Interface
REQ-001 Parameter NUM_REQ, 2, number of read requesters; index 0 = DCache, 1 = ICache.
REQ-002 Parameter ADDR_W, 32, AXI read address width.
REQ-003 Parameter DATA_W, 32, AXI read data width.
REQ-004 Parameter ID_W, 4, AXI ID width; ID_W SHALL be at least clog2(NUM_REQ).
REQ-005 Port clk  in  1  clock; all state SHALL update on the rising edge.
REQ-006 Port rst_n  in  1  asynchronous, active-low reset.
REQ-007 Port s_ar_valid/s_ar_ready  in/out  [NUM_REQ]  per-requester read-address handshake.
REQ-008 Port s_ar_addr  in  [NUM_REQ][ADDR_W]; s_ar_len in [NUM_REQ][8]; s_ar_size in [NUM_REQ][3]; s_ar_burst in [NUM_REQ][2].
REQ-009 Port s_r_valid/s_r_last  out  [NUM_REQ]; s_r_data out [NUM_REQ][DATA_W]; s_r_resp out [NUM_REQ][2]; s_r_ready in [NUM_REQ].
REQ-010 Port m_ar_valid out 1; m_ar_ready in 1; m_ar_addr/len/size/burst out; m_ar_id out [ID_W].
REQ-011 Port m_r_valid in 1; m_r_ready out 1; m_r_data in [DATA_W]; m_r_resp in 2; m_r_last in 1; m_r_id in [ID_W].
REQ-012 Port busy_o  out  1  high whenever state is not IDLE.
REQ-013 Port proto_err_o  out  1  sticky flag for a malformed read burst.

Function
REQ-014 FSM states SHALL be IDLE, ADDR and DATA; only one burst SHALL be outstanding at a time.
REQ-015 IDLE: if any s_ar_valid is high, the arbiter SHALL register grant g via round-robin, search starting at last_grant+1 modulo NUM_REQ, and go to ADDR next cycle; all s_ar_ready SHALL be 0.
REQ-016 On the same IDLE cycle, the addr/len/size/burst of g SHALL be latched into holding registers.
REQ-017 ADDR: m_ar_valid SHALL be 1, with m_ar_* driven from the holding registers and m_ar_id = g zero-extended.
REQ-018 ADDR: s_ar_ready[g] SHALL equal m_ar_ready; all other s_ar_ready SHALL be 0.
REQ-019 When m_ar_valid and m_ar_ready are both high, the FSM SHALL go to DATA, load beat_cnt = 0 and latch len_q = held len.
REQ-020 Minimum AR latency from s_ar_valid to m_ar_valid SHALL be 1 cycle; m_ar_valid SHALL NOT drop before m_ar_ready.
REQ-021 DATA routing: s_r_valid[g] = m_r_valid, with s_r_data/resp/last[g] = m_r_*, and m_r_ready = s_r_ready[g].
REQ-022 DATA: all other requesters SHALL see s_r_valid = 0, and their data, resp and last outputs SHALL be 0.
REQ-023 Each accepted beat (m_r_valid & m_r_ready) SHALL increment beat_cnt; the 8-bit count SHALL wrap at 255->0 only when len = 255.
REQ-024 An accepted beat with m_r_last = 1 SHALL return the FSM to IDLE next cycle and set last_grant = g.
REQ-025 A new grant SHALL NOT be issued in the same cycle that the last beat is accepted.
REQ-026 proto_err_o SHALL set on an accepted beat where m_r_id != g.
REQ-027 proto_err_o SHALL set when m_r_last = 1 but beat_cnt != len_q.
REQ-028 proto_err_o SHALL set when m_r_last = 0 but beat_cnt == len_q.
REQ-029 On a protocol error, routing SHALL continue unchanged and only m_r_last SHALL end the burst.
REQ-030 A requester deasserting s_ar_valid during ADDR SHALL NOT cancel the burst; the held request SHALL still issue and its data SHALL be routed normally.
REQ-031 A burst SHALL always drain to r_last; no abort path exists.
REQ-032 With all requesters continuously valid, each SHALL be granted within NUM_REQ bursts.

Reset
REQ-033 Asserting rst_n low SHALL asynchronously force: state = IDLE, last_grant = NUM_REQ-1 (so requester 0 wins first), beat_cnt = 0, proto_err_o = 0, holding registers = 0.
REQ-034 While in reset, every output SHALL be 0.
REQ-035 Reset mid-burst SHALL abandon the burst with no replay.

Structure
REQ-036 A shared cache package SHALL hold the ArbState enum (IDLE/ADDR/DATA) and the AXI constants: BURST_INCR = 2'b01, RESP_OKAY = 2'b00, SIZE_4B = 3'b010.
REQ-037 Round-robin selection SHALL be a sub-module, RoundRobinPicker (inputs req vector and last grant; output grant index and a valid bit), with purely combinational logic.

Verification
REQ-038 Single ICache request (addr 0x1C000040, len 3): m_ar_valid 1 cycle after s_ar_valid, m_ar_id = 1, 4 beats routed only to port 1, then FSM returns to IDLE.
REQ-039 Both requesters valid from reset: grants SHALL alternate 0,1,0,1 over 4 bursts, and busy_o SHALL drop for exactly 1 cycle between bursts.
REQ-040 m_ar_ready held low 5 cycles: m_ar_addr stable and s_ar_ready[g] low throughout; the handshake completes on cycle 6.
REQ-041 len = 3 burst with m_r_last on beat 2: proto_err_o = 1 the next cycle and stays high; the FSM returns to IDLE.
REQ-042 s_r_ready[g] toggled 1,0,1,0 during DATA: m_r_ready mirrors it, and no beat is lost or duplicated.
REQ-043 rst_n pulsed low during beat 2 of 4: all outputs 0 immediately; after release, requester 0 wins the next grant.

Source files
------------

// File: rtl/cache_axi_rd_arbiter_pkg.sv
// Shared definitions for the cache-side AXI read arbiter: FSM states,
// AXI field constants and a helper that sizes requester index fields.
package cache_axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [2:0] SIZE_4B    = 3'b010;

    // Width of a requester index; never zero so a single requester still gets a 1-bit field.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_axi_rd_arbiter_rr_picker.sv
// Combinational round-robin picker: searches the request vector starting one
// position after the last grant, wrapping modulo NUM_REQ.
module cache_axi_rd_arbiter_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int GW      = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [GW-1:0]      last_i,
    output logic [GW-1:0]      grant_o,
    output logic               valid_o
);

    always_comb begin
        int cand;
        cand    = 0;
        grant_o = '0;
        valid_o = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = (int'(last_i) + off) % NUM_REQ;
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                grant_o = GW'(cand);
            end
        end
    end

endmodule

// File: rtl/cache_axi_rd_arbiter.sv
// Arbitrates DCache/ICache AXI read bursts onto one master port, one burst in
// flight at a time, and flags malformed bursts returned by the interconnect.
module cache_axi_rd_arbiter
    import cache_axi_rd_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        s_ar_valid,
    output logic [NUM_REQ-1:0]        s_ar_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] s_ar_addr,
    input  logic [NUM_REQ*8-1:0]      s_ar_len,
    input  logic [NUM_REQ*3-1:0]      s_ar_size,
    input  logic [NUM_REQ*2-1:0]      s_ar_burst,
    output logic [NUM_REQ-1:0]        s_r_valid,
    output logic [NUM_REQ-1:0]        s_r_last,
    output logic [NUM_REQ*DATA_W-1:0] s_r_data,
    output logic [NUM_REQ*2-1:0]      s_r_resp,
    input  logic [NUM_REQ-1:0]        s_r_ready,
    output logic                      m_ar_valid,
    input  logic                      m_ar_ready,
    output logic [ADDR_W-1:0]         m_ar_addr,
    output logic [7:0]                m_ar_len,
    output logic [2:0]                m_ar_size,
    output logic [1:0]                m_ar_burst,
    output logic [ID_W-1:0]           m_ar_id,
    input  logic                      m_r_valid,
    output logic                      m_r_ready,
    input  logic [DATA_W-1:0]         m_r_data,
    input  logic [1:0]                m_r_resp,
    input  logic                      m_r_last,
    input  logic [ID_W-1:0]           m_r_id,
    output logic                      busy_o,
    output logic                      proto_err_o,
    output logic [1:0]                dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // m_ar_valid holds with stable fields until m_ar_ready, and R beats are passed through unbuffered.
    localparam int GW = idx_w(NUM_REQ);

    arb_state_e        state_q;
    logic [GW-1:0]     grant_q, last_grant_q, pick_grant;
    logic              pick_valid;
    logic [7:0]        beat_cnt_q, beat_cnt_d, len_q;
    logic [ADDR_W-1:0] hold_addr_q, sel_addr;
    logic [7:0]        hold_len_q, sel_len;
    logic [2:0]        hold_size_q, sel_size;
    logic [1:0]        hold_burst_q, sel_burst;
    logic              proto_err_q, beat_acc, beat_err;

    cache_axi_rd_arbiter_rr_picker #(.NUM_REQ(NUM_REQ), .GW(GW)) u_picker (
        .req_i   (s_ar_valid),
        .last_i  (last_grant_q),
        .grant_o (pick_grant),
        .valid_o (pick_valid)
    );

    always_comb begin
        sel_addr  = '0;
        sel_len   = '0;
        sel_size  = '0;
        sel_burst = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == pick_grant) begin
                sel_addr  = s_ar_addr[i*ADDR_W +: ADDR_W];
                sel_len   = s_ar_len[i*8 +: 8];
                sel_size  = s_ar_size[i*3 +: 3];
                sel_burst = s_ar_burst[i*2 +: 2];
            end
        end
    end

    assign beat_acc   = (state_q == ST_DATA) && m_r_valid && m_r_ready;
    assign beat_cnt_d = beat_cnt_q + 8'd1;
    // Wrong ID, last too early, or no last on the final expected beat.
    assign beat_err   = (m_r_id != ID_W'(grant_q)) ||
                        (m_r_last ? (beat_cnt_q != len_q) : (beat_cnt_q == len_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
            len_q        <= '0;
            hold_addr_q  <= '0;
            hold_len_q   <= '0;
            hold_size_q  <= '0;
            hold_burst_q <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_q      <= pick_grant;
                        hold_addr_q  <= sel_addr;
                        hold_len_q   <= sel_len;
                        hold_size_q  <= sel_size;
                        hold_burst_q <= sel_burst;
                        state_q      <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (m_ar_ready) begin
                        state_q    <= ST_DATA;
                        beat_cnt_q <= '0;
                        len_q      <= hold_len_q;
                    end
                end
                ST_DATA: begin
                    if (beat_acc) begin
                        beat_cnt_q <= beat_cnt_d;
                        if (beat_err) proto_err_q <= 1'b1;
                        if (m_r_last) begin
                            state_q      <= ST_IDLE;
                            last_grant_q <= grant_q;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        s_ar_ready = '0;
        s_r_valid  = '0;
        s_r_last   = '0;
        s_r_data   = '0;
        s_r_resp   = '0;
        m_r_ready  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == grant_q) begin
                if (state_q == ST_ADDR) s_ar_ready[i] = m_ar_ready;
                if (state_q == ST_DATA) begin
                    s_r_valid[i]                = m_r_valid;
                    s_r_last[i]                 = m_r_last;
                    s_r_data[i*DATA_W +: DATA_W] = m_r_data;
                    s_r_resp[i*2 +: 2]          = m_r_resp;
                    m_r_ready                   = s_r_ready[i];
                end
            end
        end
    end

    assign m_ar_valid  = (state_q == ST_ADDR);
    assign m_ar_addr   = hold_addr_q;
    assign m_ar_len    = hold_len_q;
    assign m_ar_size   = hold_size_q;
    assign m_ar_burst  = hold_burst_q;
    assign m_ar_id     = ID_W'(grant_q);
    assign busy_o      = (state_q != ST_IDLE);
    assign proto_err_o = proto_err_q;
    assign dbg_state_o = state_q;

endmodule
